// File: rtl/a_operand_buffer_if.sv
// Bus bundle for the operand-A staging buffer: matrix load request and banked read stream.
// The master side (feed/load controller) drives the matrix and controls; the buffer is the slave.
interface a_operand_buffer_if;
    logic [32767:0] matrix;
    logic           start;
    logic           output_en;
    logic [4223:0]  data_out;
    logic           load_done;

    modport master (
        output matrix,
        output start,
        output output_en,
        input  data_out,
        input  load_done
    );

    modport slave (
        input  matrix,
        input  start,
        input  output_en,
        output data_out,
        output load_done
    );
endinterface

// File: rtl/a_operand_buffer.sv
// Operand-A staging buffer: packs a 64x64 byte matrix into 16 banks (8 words each, written in
// parallel) and streams all banks out through a shared, free-running read pointer.
module a_operand_buffer (
    input  logic               clk,
    input  logic               rst_n,
    a_operand_buffer_if.slave  bus
);
    localparam int N_BANKS    = 16;
    localparam int WORD_W     = 264;
    localparam int DATA_W     = 256;
    localparam int DEPTH      = 128;
    localparam int LOAD_WORDS = 8;
    localparam logic [2:0] LAST_K = 3'(LOAD_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    logic [2:0]        k;
    logic              write_en;
    logic              load_done_r;
    logic [6:0]        rd_ptr;
    logic [WORD_W-1:0] mem [N_BANKS][DEPTH];
    logic [WORD_W-1:0] data_in [N_BANKS];

    // Word k of bank b is row (k/2)*16+b, column half k%2: 32 contiguous bytes of the matrix.
    always_comb begin
        for (int b = 0; b < N_BANKS; b++) begin
            data_in[b] = {8'd0,
                          bus.matrix[((int'(k[2:1]) * 16 + b) * 64 + int'(k[0]) * 32) * 8 +: DATA_W]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= IDLE;
            k           <= 3'd0;
            write_en    <= 1'b0;
            load_done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= WRITE;
                        k        <= 3'd0;
                        write_en <= 1'b1;
                    end
                end
                WRITE: begin
                    if (k == LAST_K) begin
                        state       <= DONE;
                        k           <= 3'd0;
                        write_en    <= 1'b0;
                        load_done_r <= 1'b1;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                DONE: begin
                    // A new load needs start to drop first, so a held start loads only once.
                    if (!bus.start) begin
                        state       <= IDLE;
                        load_done_r <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    k           <= 3'd0;
                    write_en    <= 1'b0;
                    load_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; a reset edge simply suppresses the write in progress.
    always_ff @(posedge clk) begin
        if (!rst_n && write_en) begin
            for (int b = 0; b < N_BANKS; b++) begin
                mem[b][{4'd0, k}] <= data_in[b];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            rd_ptr <= 7'd0;
        end else if (bus.output_en) begin
            rd_ptr <= rd_ptr + 7'd1;
        end
    end

    always_comb begin
        bus.data_out = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            bus.data_out[b * WORD_W +: WORD_W] = mem[b][rd_ptr];
        end
    end

    assign bus.load_done = load_done_r;
endmodule

// File: tb/tb_a_operand_buffer.sv
// Self-checking bench for a_operand_buffer: table-driven load timing plus a scoreboard of
// expected read words built from an independent byte-level packing model.
module tb_a_operand_buffer;
    localparam int NB = 16;
    localparam int WW = 264;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    a_operand_buffer_if bus();

    a_operand_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic start;
        logic oe;
        logic exp_we;
        logic exp_ld;
    } vec_t;

    typedef struct {
        logic [6:0]    ptr;
        bit            has_data;
        logic [4223:0] data;
    } exp_t;

    vec_t           vecs [12];
    exp_t           sb [$];
    logic [WW-1:0]  ref_mem [NB][8];
    logic [6:0]     model_ptr;
    bit             data_valid;
    logic [32767:0] mat_a;
    logic [32767:0] mat_b;
    logic [7:0]     pad;
    int             checks = 0;
    int             errors = 0;

    function automatic logic [WW-1:0] pack_word(input logic [32767:0] m, input int b, input int k);
        logic [WW-1:0] w;
        int r;
        int c;
        w = '0;
        for (int j = 0; j < 32; j++) begin
            r = (k / 2) * 16 + b;
            c = (k % 2) * 32 + j;
            w[j * 8 +: 8] = m[(r * 64 + c) * 8 +: 8];
        end
        return w;
    endfunction

    function automatic logic [4223:0] expected_bus(input logic [2:0] a);
        logic [4223:0] v;
        v = '0;
        for (int b = 0; b < NB; b++) begin
            v[b * WW +: WW] = ref_mem[b][a];
        end
        return v;
    endfunction

    task automatic loadModel(input logic [32767:0] m, input int first, input int last);
        for (int b = 0; b < NB; b++) begin
            for (int k = first; k <= last; k++) begin
                ref_mem[b][k] = pack_word(m, b, k);
            end
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkData(input string name, input logic [4223:0] act, input logic [4223:0] exp);
        int bad;
        checks++;
        if (act !== exp) begin
            errors++;
            bad = 0;
            for (int b = NB - 1; b >= 0; b--) begin
                if (act[b * WW +: WW] !== exp[b * WW +: WW]) bad = b;
            end
            $display("[TB] FAIL %s bank %0d actual=%h required=%h", name, bad,
                     act[bad * WW +: WW], exp[bad * WW +: WW]);
        end
    endtask

    // Drive one cycle's inputs and record what the read port must show during that cycle.
    task automatic applyStimulus(input logic s, input logic oe);
        exp_t e;
        bus.start     = s;
        bus.output_en = oe;
        e.ptr      = model_ptr;
        e.has_data = data_valid && (model_ptr < 7'd8);
        e.data     = e.has_data ? expected_bus(model_ptr[2:0]) : '0;
        sb.push_back(e);
        if (oe) model_ptr = model_ptr + 7'd1;
    endtask

    task automatic checkOutput();
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty actual=0 required=1");
        end else begin
            e = sb.pop_front();
            checkVal("rd_ptr", 32'(dut.rd_ptr), 32'(e.ptr));
            if (e.has_data) checkData($sformatf("data_addr%0d", e.ptr), bus.data_out, e.data);
        end
    endtask

    task automatic finishCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic s, input logic oe);
        applyStimulus(s, oe);
        checkOutput();
        finishCycle();
    endtask

    task automatic doReset();
        rst_n         = 1'b1;
        bus.start     = 1'b0;
        bus.output_en = 1'b0;
        finishCycle();
        rst_n     = 1'b0;
        model_ptr = 7'd0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int r = 0; r < 64; r++) begin
            for (int c = 0; c < 64; c++) begin
                mat_a[(r * 64 + c) * 8 +: 8] = 8'((r * 64 + c) % 256);
                mat_b[(r * 64 + c) * 8 +: 8] = 8'(255 - ((r * 64 + c) % 256));
            end
        end
        // Start held for 10 edges, then dropped: 8 write cycles, done held, then back to idle.
        for (int i = 0; i < 12; i++) begin
            vecs[i].start  = (i < 10);
            vecs[i].oe     = 1'b0;
            vecs[i].exp_we = (i <= 7);
            vecs[i].exp_ld = (i == 8) || (i == 9);
        end

        bus.matrix    = mat_a;
        bus.start     = 1'b0;
        bus.output_en = 1'b0;
        data_valid    = 1'b0;
        model_ptr     = 7'd0;
        rst_n         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;

        checkVal("reset_load_done", 32'(bus.load_done), 32'd0);
        checkVal("reset_write_en", 32'(dut.write_en), 32'd0);
        checkVal("reset_rd_ptr", 32'(dut.rd_ptr), 32'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].start, vecs[i].oe);
            checkOutput();
            finishCycle();
            checkVal($sformatf("vec%0d_write_en", i), 32'(dut.write_en), 32'(vecs[i].exp_we));
            checkVal($sformatf("vec%0d_load_done", i), 32'(bus.load_done), 32'(vecs[i].exp_ld));
        end
        loadModel(mat_a, 0, 7);
        data_valid = 1'b1;

        for (int m = 0; m < 8; m++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput();
            if (m == 0) begin
                checkVal("b3_a0_byte0", 32'(bus.data_out[3 * WW +: 8]), 32'd192);
                checkVal("b3_a0_byte31", 32'(bus.data_out[3 * WW + 31 * 8 +: 8]), 32'd223);
            end
            if (m == 1) checkVal("b3_a1_byte0", 32'(bus.data_out[3 * WW +: 8]), 32'd224);
            if (m == 7) checkVal("b15_a7_byte31", 32'(bus.data_out[15 * WW + 31 * 8 +: 8]), 32'd255);
            pad = '0;
            for (int b = 0; b < NB; b++) pad = pad | bus.data_out[b * WW + 256 +: 8];
            checkVal($sformatf("pad_addr%0d", m), 32'(pad), 32'd0);
            finishCycle();
        end

        // Reset after four writes of a B load: entries 0..3 become B, 4..7 keep A.
        bus.matrix = mat_b;
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0);
        rst_n     = 1'b0;
        model_ptr = 7'd0;
        checkVal("midreset_write_en", 32'(dut.write_en), 32'd0);
        checkVal("midreset_load_done", 32'(bus.load_done), 32'd0);
        checkVal("midreset_rd_ptr", 32'(dut.rd_ptr), 32'd0);
        loadModel(mat_b, 0, 3);

        // Start is still high, so a fresh load runs while the mixed contents are read out.
        for (int m = 0; m < 8; m++) cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        checkVal("reload_load_done", 32'(bus.load_done), 32'd1);
        checkVal("reload_write_en", 32'(dut.write_en), 32'd0);
        loadModel(mat_b, 0, 7);
        cycle(1'b0, 1'b0);
        checkVal("drop_start_load_done", 32'(bus.load_done), 32'd0);

        doReset();
        for (int m = 0; m < 8; m++) cycle(1'b0, 1'b1);

        doReset();
        for (int m = 0; m < 3; m++) cycle(1'b0, 1'b1);
        for (int m = 0; m < 5; m++) begin
            cycle(1'b0, 1'b0);
            checkVal("frozen_rd_ptr", 32'(dut.rd_ptr), 32'd3);
        end
        cycle(1'b0, 1'b1);

        doReset();
        for (int m = 0; m < 130; m++) cycle(1'b0, 1'b1);
        checkVal("wrap_rd_ptr", 32'(dut.rd_ptr), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
